// File: rtl/rtc_pkg.sv
// Shared constants, scanner state encoding and named RTC register addresses
// for the RTC memory scheduler.
package rtc_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int SCAN_LAST = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } scan_state_t;

    typedef enum logic {
        WIN_RTC,
        WIN_USR
    } winner_t;

    // RTC register map: time/date bytes, then the chronometer bytes
    localparam logic [ADDR_W-1:0] SEC     = 4'd0;
    localparam logic [ADDR_W-1:0] MIN     = 4'd1;
    localparam logic [ADDR_W-1:0] HOUR    = 4'd2;
    localparam logic [ADDR_W-1:0] DAY     = 4'd3;
    localparam logic [ADDR_W-1:0] MON     = 4'd4;
    localparam logic [ADDR_W-1:0] YEAR    = 4'd5;
    localparam logic [ADDR_W-1:0] CR_SEC  = 4'd8;
    localparam logic [ADDR_W-1:0] CR_MIN  = 4'd9;
    localparam logic [ADDR_W-1:0] CR_HOUR = 4'd10;

endpackage

// File: rtl/rtc_wr_arb.sv
// Two-way round-robin write arbiter (RTC readback vs user edit) with registered
// memory write outputs. Optional RTC_SCHED_LOCK_EN adds usr_lock, which blocks the RTC path.
module rtc_wr_arb #(
    parameter int ADDR_W = rtc_pkg::ADDR_W,
    parameter int DATA_W = rtc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rtc_req,
    input  logic [ADDR_W-1:0] rtc_add,
    input  logic [DATA_W-1:0] rtc_dat,
    output logic              rtc_gnt,
    input  logic              usr_req,
    input  logic [ADDR_W-1:0] usr_add,
    input  logic [DATA_W-1:0] usr_dat,
`ifdef RTC_SCHED_LOCK_EN
    input  logic              usr_lock,
`endif
    output logic              usr_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wadd,
    output logic [DATA_W-1:0] mem_wdat
);
    import rtc_pkg::*;

    winner_t last_winner;
    logic    grant_rtc;
    logic    grant_usr;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_rtc = 1'b0;
        grant_usr = 1'b0;
        if (rtc_req && usr_req) begin
            grant_rtc = (last_winner == WIN_USR);
            grant_usr = (last_winner == WIN_RTC);
        end else begin
            grant_rtc = rtc_req;
            grant_usr = usr_req;
        end
`ifdef RTC_SCHED_LOCK_EN
        if (usr_lock) begin
            grant_rtc = 1'b0;
            grant_usr = usr_req;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtc_gnt     <= 1'b0;
            usr_gnt     <= 1'b0;
            mem_we      <= 1'b0;
            mem_wadd    <= '0;
            mem_wdat    <= '0;
            last_winner <= WIN_USR;
        end else begin
            rtc_gnt <= grant_rtc;
            usr_gnt <= grant_usr;
            mem_we  <= grant_rtc | grant_usr;
            if (grant_rtc) begin
                mem_wadd    <= rtc_add;
                mem_wdat    <= rtc_dat;
                last_winner <= WIN_RTC;
            end else if (grant_usr) begin
                mem_wadd    <= usr_add;
                mem_wdat    <= usr_dat;
                last_winner <= WIN_USR;
            end
        end
    end

endmodule

// File: rtl/rtc_mem_sched.sv
// RTC register memory front-end: round-robin write port plus a read-port scanner that
// streams {address, byte} pairs. Optional RTC_SCHED_LOCK_EN adds the usr_lock input.
module rtc_mem_sched #(
    parameter int ADDR_W    = rtc_pkg::ADDR_W,
    parameter int DATA_W    = rtc_pkg::DATA_W,
    parameter int SCAN_LAST = rtc_pkg::SCAN_LAST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rtc_req,
    input  logic [ADDR_W-1:0] rtc_add,
    input  logic [DATA_W-1:0] rtc_dat,
    output logic              rtc_gnt,
    input  logic              usr_req,
    input  logic [ADDR_W-1:0] usr_add,
    input  logic [DATA_W-1:0] usr_dat,
`ifdef RTC_SCHED_LOCK_EN
    input  logic              usr_lock,
`endif
    output logic              usr_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wadd,
    output logic [DATA_W-1:0] mem_wdat,
    output logic [ADDR_W-1:0] mem_radd,
    input  logic [DATA_W-1:0] mem_rdat,
    input  logic              scan_go,
    output logic              scan_busy,
    output logic              disp_vld,
    output logic [ADDR_W-1:0] disp_add,
    output logic [DATA_W-1:0] disp_dat
);
    import rtc_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADD = ADDR_W'(SCAN_LAST);

    scan_state_t       state;
    scan_state_t       state_nx;
    logic [ADDR_W-1:0] radd_nx;

    rtc_wr_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_arb (
        .clk      (clk),
        .reset    (reset),
        .rtc_req  (rtc_req),
        .rtc_add  (rtc_add),
        .rtc_dat  (rtc_dat),
        .rtc_gnt  (rtc_gnt),
        .usr_req  (usr_req),
        .usr_add  (usr_add),
        .usr_dat  (usr_dat),
`ifdef RTC_SCHED_LOCK_EN
        .usr_lock (usr_lock),
`endif
        .usr_gnt  (usr_gnt),
        .mem_we   (mem_we),
        .mem_wadd (mem_wadd),
        .mem_wdat (mem_wdat)
    );

    always_comb begin
        state_nx = state;
        radd_nx  = mem_radd;
        case (state)
            S_IDLE: begin
                if (scan_go) begin
                    state_nx = S_RUN;
                    radd_nx  = '0;
                end
            end
            S_RUN: begin
                // Counter parks on the last address; the final read is collected in S_DRAIN
                if (mem_radd == LAST_ADD) state_nx = S_DRAIN;
                else                      radd_nx  = mem_radd + 1'b1;
            end
            S_DRAIN: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mem_radd <= '0;
        end else begin
            state    <= state_nx;
            mem_radd <= radd_nx;
        end
    end

    // The memory answers one cycle after mem_radd, so the address is delayed to meet its data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_vld <= 1'b0;
            disp_add <= '0;
        end else begin
            disp_vld <= (state == S_RUN);
            if (state == S_RUN) disp_add <= mem_radd;
        end
    end

    assign scan_busy = (state == S_RUN);
    assign disp_dat  = disp_vld ? mem_rdat : '0;

endmodule

// File: tb/tb_rtc_mem_sched.sv
// Self-checking bench for rtc_mem_sched: cycle model of arbitration and sweep timing,
// an environment memory, and directed vectors with literal expectations.
module tb_rtc_mem_sched;
    import rtc_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rtc_req = 1'b0, usr_req = 1'b0, scan_go = 1'b0;
    logic [AW-1:0] rtc_add = '0, usr_add = '0;
    logic [DW-1:0] rtc_dat = '0, usr_dat = '0;
`ifdef RTC_SCHED_LOCK_EN
    logic          usr_lock = 1'b0;
`endif
    logic          rtc_gnt, usr_gnt, mem_we, scan_busy, disp_vld;
    logic [AW-1:0] mem_wadd, mem_radd, disp_add;
    logic [DW-1:0] mem_wdat, disp_dat;
    logic [DW-1:0] mem_rdat;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rtc_mem_sched #(.ADDR_W(AW), .DATA_W(DW), .SCAN_LAST(N-1)) dut (
        .clk(clk), .reset(reset),
        .rtc_req(rtc_req), .rtc_add(rtc_add), .rtc_dat(rtc_dat), .rtc_gnt(rtc_gnt),
        .usr_req(usr_req), .usr_add(usr_add), .usr_dat(usr_dat),
`ifdef RTC_SCHED_LOCK_EN
        .usr_lock(usr_lock),
`endif
        .usr_gnt(usr_gnt),
        .mem_we(mem_we), .mem_wadd(mem_wadd), .mem_wdat(mem_wdat),
        .mem_radd(mem_radd), .mem_rdat(mem_rdat),
        .scan_go(scan_go), .scan_busy(scan_busy),
        .disp_vld(disp_vld), .disp_add(disp_add), .disp_dat(disp_dat)
    );

    // Environment memory: synchronous write, registered read (old data on same-edge collision)
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (mem_we) ram[mem_wadd] <= mem_wdat;
        mem_rdat <= ram[mem_radd];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Sweep accepted at edge k: after edge k+j, address j is on the read port (j<N),
    // pair j-1 is on the display port (1<=j<=N); idle again from edge k+N+1.
    logic [DW-1:0] model_mem [16];
    int            edge_cnt = 0;
    int            go_edge = -1000;
    int            mj;
    logic          m_last_usr;
    logic          win_r, win_u;
    logic          exp_we, exp_rgnt, exp_ugnt, exp_busy, exp_vld;
    logic [AW-1:0] exp_wadd, exp_radd, exp_add;
    logic [DW-1:0] exp_wdat, exp_dat;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            {exp_we, exp_rgnt, exp_ugnt, exp_busy, exp_vld} = '0;
            exp_wadd = '0; exp_radd = '0; exp_add = '0;
            exp_wdat = '0; exp_dat = '0;
            m_last_usr = 1'b1;
            go_edge = -1000;
        end else begin
            edge_cnt++;
            mj = edge_cnt - 1 - go_edge;
            if (scan_go && mj >= N + 1) go_edge = edge_cnt;
            mj = edge_cnt - go_edge;
            exp_busy = (mj >= 0 && mj <= N - 1);
            if (exp_busy) exp_radd = AW'(mj);
            exp_vld = (mj >= 1 && mj <= N);
            if (exp_vld) begin
                exp_add = AW'(mj - 1);
                exp_dat = model_mem[mj - 1];
            end
            // write granted on the previous edge lands in memory now
            if (exp_we) model_mem[exp_wadd] = exp_wdat;
            win_r = 1'b0;
            win_u = 1'b0;
            if (rtc_req && usr_req) begin
                win_r = m_last_usr;
                win_u = !m_last_usr;
            end else begin
                win_r = rtc_req;
                win_u = usr_req;
            end
`ifdef RTC_SCHED_LOCK_EN
            if (usr_lock) begin
                win_r = 1'b0;
                win_u = usr_req;
            end
`endif
            exp_rgnt = win_r;
            exp_ugnt = win_u;
            exp_we   = win_r | win_u;
            if (win_r) begin
                exp_wadd = rtc_add; exp_wdat = rtc_dat; m_last_usr = 1'b0;
            end else if (win_u) begin
                exp_wadd = usr_add; exp_wdat = usr_dat; m_last_usr = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("mem_we", mem_we, exp_we);
            check("mem_wadd", mem_wadd, exp_wadd);
            check("mem_wdat", mem_wdat, exp_wdat);
            check("rtc_gnt", rtc_gnt, exp_rgnt);
            check("usr_gnt", usr_gnt, exp_ugnt);
            check("mem_radd", mem_radd, exp_radd);
            check("scan_busy", scan_busy, exp_busy);
            check("disp_vld", disp_vld, exp_vld);
            check("disp_dat", disp_dat, exp_vld ? exp_dat : 8'h00);
            if (exp_vld) check("disp_add", disp_add, exp_add);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [AW-1:0] cap_add [16];
    logic [DW-1:0] cap_dat [16];

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_wadd"}, mem_wadd, 0);
        check({tag, "_wdat"}, mem_wdat, 0);
        check({tag, "_radd"}, mem_radd, 0);
        check({tag, "_gnts"}, {rtc_gnt, usr_gnt}, 0);
        check({tag, "_busy"}, scan_busy, 0);
        check({tag, "_vld"}, disp_vld, 0);
        check({tag, "_dadd"}, disp_add, 0);
        check({tag, "_ddat"}, disp_dat, 0);
    endtask

    task automatic run_sweep(input int repulse_c, input int write_c,
                             output int n_pairs, output int busy_low_c);
        n_pairs = 0;
        busy_low_c = -1;
        scan_go = 1'b1;
        @(posedge clk); #1;
        scan_go = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (disp_vld) begin
                if (n_pairs < 16) begin
                    cap_add[n_pairs] = disp_add;
                    cap_dat[n_pairs] = disp_dat;
                end
                n_pairs++;
            end
            if (!scan_busy && busy_low_c < 0) busy_low_c = c;
            scan_go = (c == repulse_c);
            rtc_req = (c == write_c);
            rtc_add = 4'd9;
            rtc_dat = 8'h5A;
            @(posedge clk); #1;
        end
        scan_go = 1'b0;
        rtc_req = 1'b0;
    endtask

    int            pairs, busy_low;
    logic [1:0]    gseq_r, gseq_u;
    logic [3:0]    seq_r, seq_u;
    logic [DW-1:0] exp8;
    int            ug, rg;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i] = DW'(8'h10 + i);
            model_mem[i] = DW'(8'h10 + i);
        end
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // contention from reset: RTC, USR, RTC, USR
        rtc_req = 1'b1; rtc_add = 4'd14; rtc_dat = 8'hA0;
        usr_req = 1'b1; usr_add = 4'd15; usr_dat = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seq_r[i] = rtc_gnt;
            seq_u[i] = usr_gnt;
        end
        rtc_req = 1'b0;
        usr_req = 1'b0;
        check("contend_rtc_seq", seq_r, 4'b0101);
        check("contend_usr_seq", seq_u, 4'b1010);
        @(posedge clk); #1;
        gseq_r = {rtc_gnt, usr_gnt};
        check("contend_idle_gnts", gseq_r, 2'b00);

        // plain sweep over preloaded bytes
        run_sweep(0, 0, pairs, busy_low);
        check("sweep_pairs", pairs, N);
        check("sweep_busy_low", busy_low, 13);
        for (int i = 0; i < N; i++) begin
            exp8 = DW'(8'h10 + i);
            check("sweep_add", cap_add[i], i);
            check("sweep_dat", cap_dat[i], exp8);
        end

        // scan_go re-pulsed during the sweep is ignored
        run_sweep(3, 0, pairs, busy_low);
        check("repulse_pairs", pairs, N);
        check("repulse_busy_low", busy_low, 13);
        check("repulse_last_add", cap_add[N-1], N - 1);

        // single user writer
        usr_req = 1'b1; usr_add = HOUR; usr_dat = 8'h15;
        @(posedge clk); #1;
        usr_req = 1'b0;
        check("single_we", mem_we, 1);
        check("single_wadd", mem_wadd, 2);
        check("single_wdat", mem_wdat, 8'h15);
        check("single_usr_gnt", usr_gnt, 1);
        check("single_rtc_gnt", rtc_gnt, 0);
        @(posedge clk); #1;
        check("single_we_drop", mem_we, 0);
        check("single_wadd_hold", mem_wadd, 2);

        // sweep with an RTC write to address 9 landing before address 9 is read
        run_sweep(0, 1, pairs, busy_low);
        check("wsweep_pairs", pairs, N);
        check("wsweep_dat2", cap_dat[2], 8'h15);
        check("wsweep_dat9", cap_dat[9], 8'h5A);
        check("wsweep_dat11", cap_dat[11], 8'h1B);

        // reset in the middle of a sweep
        scan_go = 1'b1;
        @(posedge clk); #1;
        scan_go = 1'b0;
        for (int k = 0; k < 20 && mem_radd != 4'd5; k++) begin
            @(posedge clk); #1;
        end
        check("midreset_radd5", mem_radd, 5);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("postreset_vld", disp_vld, 0);
        scan_go = 1'b1;
        @(posedge clk); #1;
        scan_go = 1'b0;
        check("restart_radd", mem_radd, 0);
        check("restart_busy", scan_busy, 1);
        repeat (16) @(posedge clk);
        #1;

`ifdef RTC_SCHED_LOCK_EN
        usr_lock = 1'b1;
        rtc_req = 1'b1; rtc_add = 4'd14; rtc_dat = 8'hC1;
        usr_req = 1'b1; usr_add = 4'd15; usr_dat = 8'hD1;
        ug = 0;
        rg = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ug += int'(usr_gnt);
            rg += int'(rtc_gnt);
        end
        usr_lock = 1'b0;
        usr_req = 1'b0;
        check("lock_usr_gnts", ug, 3);
        check("lock_rtc_gnts", rg, 0);
        @(posedge clk); #1;
        rtc_req = 1'b0;
        check("unlock_rtc_gnt", rtc_gnt, 1);
        check("unlock_wadd", mem_wadd, 14);
        @(posedge clk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
